// File: rtl/touch_pad_debounce.sv
// Touch-pad conditioner: per-pad 2-flop sync, stable-time debounce,
// debounced level plus press/release/long-press strobes.
`timescale 1ns/1ps
module touch_pad_debounce #(
  parameter int PADS            = 2,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int LONG_CYCLES     = 48000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PADS-1:0] pad_n,
  output logic [PADS-1:0] pressed,
  output logic [PADS-1:0] press_pulse,
  output logic [PADS-1:0] release_pulse,
  output logic [PADS-1:0] long_pulse
);

  localparam int CW =
    (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST =
    CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  logic [PADS-1:0] r_meta;
  logic [PADS-1:0] r_sync;

  // Pads idle high through the pull-ups, so reset to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= pad_n;
      r_sync <= r_meta;
    end
  end

  for (genvar g = 0; g < PADS; g++) begin : g_pad
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_cnt_inc;
    logic          r_long_seen;
    logic          w_long_seen_nx;
    logic          w_sync;
    logic          w_press;
    logic          w_release;
    logic          w_long;
    logic          w_pressed_nx;
    logic          r_pressed;
    logic          r_press;
    logic          r_release;
    logic          r_long;

    assign w_sync = r_sync[g];
    assign w_cnt_inc =
      (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_pressed_nx =
      (w_state_nx == HELD) ||
      (w_state_nx == REL_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_long_seen <= 1'b0;
        r_pressed   <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_state     <= w_state_nx;
        r_cnt       <= w_cnt_nx;
        r_long_seen <= w_long_seen_nx;
        r_pressed   <= w_pressed_nx;
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
      end
    end

    // Raw sync level is checked before the count so a glitch
    // landing on the accept edge still restarts the wait.
    always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_long_seen_nx = r_long_seen;
      w_press        = 1'b0;
      w_release      = 1'b0;
      w_long         = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_sync) begin
            w_state_nx = PRESS_WAIT;
            w_cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (w_sync) begin
            w_state_nx = IDLE;
          end else if (r_cnt == DB_LAST) begin
            w_state_nx = HELD;
            w_cnt_nx   = '0;
            w_press    = 1'b1;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        HELD: begin
          if (w_sync) begin
            w_state_nx = REL_WAIT;
            w_cnt_nx   = '0;
          end else if (!r_long_seen &&
                       r_cnt == LONG_LAST) begin
            w_long_seen_nx = 1'b1;
            w_long         = 1'b1;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        REL_WAIT: begin
          if (!w_sync) begin
            w_state_nx = HELD;
            w_cnt_nx   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nx     = IDLE;
            w_cnt_nx       = '0;
            w_long_seen_nx = 1'b0;
            w_release      = 1'b1;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end

    assign pressed[g]       = r_pressed;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;
    assign long_pulse[g]    = r_long;
  end

endmodule

// File: tb/tb_touch_pad_debounce.sv
// Bench for touch_pad_debounce: timed strobe scoreboard
// plus inline level checks, one task per scenario.
`timescale 1ns/1ps
module tb_touch_pad_debounce;

  localparam int PADS = 2;
  localparam int DB   = 4;
  localparam int LNG  = 16;
  localparam int LAT  = DB + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int pad;
    int kind;
  } ev_t;

  logic            clk;
  logic            rst_n;
  logic [PADS-1:0] pad_n;
  logic [PADS-1:0] pressed;
  logic [PADS-1:0] press_pulse;
  logic [PADS-1:0] release_pulse;
  logic [PADS-1:0] long_pulse;

  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;
  ev_t sb[$];

  touch_pad_debounce #(
    .PADS(PADS),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LNG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pad_n(pad_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed strobe must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0] s;
    ev_t e;
    for (int p = 0; p < PADS; p++) begin
      s = {long_pulse[p], release_pulse[p], press_pulse[p]};
      for (int k = 0; k < 3; k++) begin
        if (s[k]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL strobe_unexpected cyc=%0d pad=%0d kind=%0d required=none",
                     cyc, p, k);
          end else begin
            e = sb.pop_front();
            if (e.cyc !== cyc || e.pad !== p ||
                e.kind !== k) begin
              failures++;
              $display("FAIL strobe got cyc=%0d pad=%0d kind=%0d required cyc=%0d pad=%0d kind=%0d",
                       cyc, p, k, e.cyc, e.pad, e.kind);
            end
          end
        end
      end
    end
  end

  task automatic push(input int at, input int p, input int k);
    sb.push_back(ev_t'{at, p, k});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pad_n = 2'b00;
    step(3);
    checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse}
        !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=00",
               {pressed, press_pulse, release_pulse, long_pulse});
    end
    rst_n = 1'b1;
    push(cyc + LAT, 0, K_PRESS);
    push(cyc + LAT, 1, K_PRESS);
    step(LAT - 1);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL reset_early_press got=%b required=00", pressed);
    end
    step(1);
    checks++;
    if (pressed !== 2'b11) begin
      failures++;
      $display("FAIL reset_exit_press got=%b required=11", pressed);
    end
    pad_n = 2'b11;
    push(cyc + LAT, 0, K_REL);
    push(cyc + LAT, 1, K_REL);
    step(LAT);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got=%b required=00", pressed);
    end
    step(2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL reset_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_clean_press();
    pad_n[0] = 1'b0;
    push(cyc + LAT, 0, K_PRESS);
    step(LAT - 1);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL clean_early got=%b required=00", pressed);
    end
    step(1);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL clean_press got=%b required=01", pressed);
    end
    pad_n[0] = 1'b1;
    push(cyc + LAT, 0, K_REL);
    step(LAT - 1);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL clean_early_rel got=%b required=01", pressed);
    end
    step(1);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL clean_release got=%b required=00", pressed);
    end
    step(2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL clean_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      pad_n[0] = 1'b0;
      step(3);
      pad_n[0] = 1'b1;
      step(1);
    end
    step(8);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL bounce_level got=%b required=00", pressed);
    end
    pad_n[0] = 1'b0;
    push(cyc + LAT, 0, K_PRESS);
    step(LAT + 1);
    pad_n[0] = 1'b1;
    step(1);
    pad_n[0] = 1'b0;
    step(10);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL held_glitch got=%b required=01", pressed);
    end
    pad_n[0] = 1'b1;
    push(cyc + LAT, 0, K_REL);
    step(LAT);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL bounce_release got=%b required=00", pressed);
    end
    step(2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL bounce_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_long_press();
    pad_n[0] = 1'b0;
    push(cyc + LAT, 0, K_PRESS);
    push(cyc + LAT + LNG, 0, K_LONG);
    step(LAT + LNG);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL long_level got=%b required=01", pressed);
    end
    pad_n[0] = 1'b1;
    step(2);
    pad_n[0] = 1'b0;
    step(LNG + 10);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL long_bounce got=%b required=01", pressed);
    end
    pad_n[0] = 1'b1;
    push(cyc + LAT, 0, K_REL);
    step(LAT);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL long_release got=%b required=00", pressed);
    end
    step(2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL long_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_independent();
    pad_n = 2'b00;
    push(cyc + LAT, 0, K_PRESS);
    push(cyc + LAT, 1, K_PRESS);
    step(LAT);
    checks++;
    if (pressed !== 2'b11) begin
      failures++;
      $display("FAIL indep_both got=%b required=11", pressed);
    end
    pad_n = 2'b10;
    push(cyc + LAT, 1, K_REL);
    step(LAT);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL indep_pad1 got=%b required=01", pressed);
    end
    pad_n = 2'b11;
    push(cyc + LAT, 0, K_REL);
    step(LAT);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL indep_pad0 got=%b required=00", pressed);
    end
    step(2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL indep_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_async_reset();
    pad_n[0] = 1'b0;
    push(cyc + LAT, 0, K_PRESS);
    step(LAT + 1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse}
        !== 8'h00) begin
      failures++;
      $display("FAIL async_clear got=%h required=00",
               {pressed, press_pulse, release_pulse, long_pulse});
    end
    push(cyc + LAT, 0, K_PRESS);
    #1 rst_n = 1'b1;
    step(LAT - 1);
    checks++;
    if (pressed !== 2'b00) begin
      failures++;
      $display("FAIL async_early got=%b required=00", pressed);
    end
    step(1);
    checks++;
    if (pressed !== 2'b01) begin
      failures++;
      $display("FAIL async_repress got=%b required=01", pressed);
    end
    pad_n[0] = 1'b1;
    push(cyc + LAT, 0, K_REL);
    step(LAT + 2);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL async_pending got=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    pad_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_independent();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
